// File: rtl/acl_sched_pkg.sv
// acl_sched_pkg: shared state encoding and default widths for the ACL frame scheduler.
package acl_sched_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_DEC, FWD, DROP} state_t;
   localparam int DROP_CNT_W     = 16;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_CNT_W      = 9;
   localparam int DEF_LENQ_DEPTH = 4;
endpackage

// File: rtl/acl_len_fifo.sv
// acl_len_fifo: register-array queue of pending frame lengths; pushes while full are discarded.
module acl_len_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = din;
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/acl_frame_sched.sv
// acl_frame_sched: forwards or drops whole frames from the ingress FIFO by ACL decision.
// Define ACL_DROP_CNT_EN to build the saturating dropped-frame counter.
module acl_frame_sched
   import acl_sched_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int LENQ_DEPTH = DEF_LENQ_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_frame_end,
   input  logic [CNT_W-1:0]      i_frame_len,
   input  logic [CNT_W-1:0]      i_wr_cnt,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_acl_valid,
   input  logic                  i_acl_permit,
   output logic                  o_acl_ready,
   output logic                  o_rd_valid,
   output logic                  o_fifo_invalid,
   output logic [DATA_W-1:0]     o_txd_tdata,
   output logic                  o_txd_tvalid,
   output logic                  o_txd_tlast,
   input  logic                  i_txd_tready,
   output logic [DROP_CNT_W-1:0] o_drop_cnt,
   output logic                  o_err
);
   localparam int QW = $clog2(LENQ_DEPTH) + 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, q_head;
   logic             err_q, err_d, q_full, q_empty, q_push, q_pop;
   logic [QW-1:0]    q_count;

   // Zero-length frames never enter the queue; full-queue pushes are dropped inside it.
   assign q_push = i_frame_end && i_frame_len != '0;
   assign err_d  = err_q || (i_frame_end && (q_full || i_frame_len == '0));

   acl_len_fifo #(.W(CNT_W), .DEPTH(LENQ_DEPTH)) u_lenq (
      .clk(clk), .rst(rst), .push(q_push), .pop(q_pop), .din(i_frame_len),
      .dout(q_head), .full(q_full), .empty(q_empty), .count(q_count)
   );

   assign o_fifo_invalid = rst || q_count >= QW'(LENQ_DEPTH - 1);
   assign o_txd_tdata    = i_data;
   assign o_err          = err_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      q_pop        = 1'b0;
      o_acl_ready  = 1'b0;
      o_txd_tvalid = 1'b0;
      o_txd_tlast  = 1'b0;
      o_rd_valid   = 1'b0;
      case (state_q)
         IDLE: if (!q_empty) begin
            state_d = WAIT_DEC;
            cnt_d   = q_head;
         end
         WAIT_DEC: begin
            o_acl_ready = 1'b1;
            if (i_acl_valid) begin
               q_pop   = 1'b1;
               state_d = i_acl_permit ? FWD : DROP;
            end
         end
         FWD: begin
            o_txd_tvalid = i_wr_cnt != '0;
            o_txd_tlast  = cnt_q == CNT_W'(1);
            o_rd_valid   = o_txd_tvalid && i_txd_tready;
         end
         DROP: o_rd_valid = i_wr_cnt != '0;
         default: state_d = IDLE;
      endcase
      if (o_rd_valid) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

`ifdef ACL_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_q, drop_d;
   logic                  drop_done;
   assign drop_done = state_q == DROP && o_rd_valid && cnt_q == CNT_W'(1);
   assign drop_d    = (drop_done && drop_q != '1) ? drop_q + 1'b1 : drop_q;
   assign o_drop_cnt = drop_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end
`else
   assign o_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_acl_frame_sched.sv
// tb_acl_frame_sched: directed and randomized frame traffic against a frame-level scoreboard.
// Models the ingress FIFO as a word queue; expects o_drop_cnt only when ACL_DROP_CNT_EN is defined.
module tb_acl_frame_sched;
   localparam int DW = 32;
   localparam int CW = 9;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_frame_end = 1'b0, i_acl_valid = 1'b0, i_acl_permit = 1'b0, i_txd_tready = 1'b0;
   logic [CW-1:0] i_frame_len = '0, i_wr_cnt = '0;
   logic [DW-1:0] i_data = '0;
   logic          o_acl_ready, o_rd_valid, o_fifo_invalid, o_txd_tvalid, o_txd_tlast, o_err;
   logic [DW-1:0] o_txd_tdata;
   logic [15:0]   o_drop_cnt;

   acl_frame_sched dut (
      .clk(clk), .rst(rst), .i_frame_end(i_frame_end), .i_frame_len(i_frame_len),
      .i_wr_cnt(i_wr_cnt), .i_data(i_data), .i_acl_valid(i_acl_valid), .i_acl_permit(i_acl_permit),
      .o_acl_ready(o_acl_ready), .o_rd_valid(o_rd_valid), .o_fifo_invalid(o_fifo_invalid),
      .o_txd_tdata(o_txd_tdata), .o_txd_tvalid(o_txd_tvalid), .o_txd_tlast(o_txd_tlast),
      .i_txd_tready(i_txd_tready), .o_drop_cnt(o_drop_cnt), .o_err(o_err)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fifo_q[$];
   beat_t         exp_q[$];
   logic          dec_q[$];
   int            n_chk = 0, n_pass = 0;
   int            pending = 0, drop_exp = 0, drop_words_exp = 0, dpop_cnt = 0;
   int            hs_cnt = 0, first_hs = 0, last_hs = 0, tvalid_seen = 0, cyc = 0, rdy_mode = 0;
   bit            push_pend = 0, err_pend = 0, hold_dec = 0, stall_prev = 0, tog = 1;
   logic          err_exp = 1'b0;
   logic [DW-1:0] stall_data = '0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   function automatic logic [15:0] exp_drop();
`ifdef ACL_DROP_CNT_EN
      return drop_exp > 65535 ? 16'hFFFF : 16'(drop_exp);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic refresh();
      i_wr_cnt     = CW'(fifo_q.size());
      i_data       = fifo_q.size() != 0 ? fifo_q[0] : '0;
      i_acl_valid  = !hold_dec && dec_q.size() != 0 && (rdy_mode != 2 || $urandom_range(0, 1) == 1);
      i_acl_permit = dec_q.size() != 0 ? dec_q[0] : 1'b0;
   endtask

   // A frame's words land in the FIFO together with its frame_end pulse.
   task automatic push_frame(int len, bit permit);
      logic [DW-1:0] w;
      bit ok;
      ok = len != 0 && pending < 4;
      if (ok) begin
         for (int i = 0; i < len; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            if (permit) exp_q.push_back('{w, i == len - 1});
         end
         dec_q.push_back(permit);
         if (!permit) begin
            drop_exp++;
            drop_words_exp += len;
         end
      end
      push_pend   = ok;
      err_pend    = !ok;
      i_frame_end = 1'b1;
      i_frame_len = CW'(len);
      refresh();
   endtask

   task automatic tick();
      logic rd, hs, acc;
      beat_t e;
      @(negedge clk);
      rd  = o_rd_valid;
      hs  = o_txd_tvalid && i_txd_tready;
      acc = o_acl_ready && i_acl_valid;
      check("fifo_invalid", o_fifo_invalid, pending >= 3);
      check("err", o_err, err_exp);
      check("drop_cnt", o_drop_cnt, exp_drop());
      if (rd) check("pop_nonempty", i_wr_cnt != '0, 1);
      if (o_txd_tvalid) begin
         tvalid_seen++;
         check("rd_follows_ready", rd, i_txd_tready);
      end
      if (stall_prev) begin
         check("hold_valid", o_txd_tvalid, 1);
         check("hold_data", o_txd_tdata, stall_data);
      end
      if (hs) begin
         if (exp_q.size() == 0) check("unexpected_beat", hs, 0);
         else begin
            e = exp_q.pop_front();
            check("tdata", o_txd_tdata, e.data);
            check("tlast", o_txd_tlast, e.last);
         end
         if (hs_cnt == 0) first_hs = cyc;
         last_hs = cyc;
         hs_cnt++;
      end
      if (rd && !o_txd_tvalid) dpop_cnt++;
      stall_prev = o_txd_tvalid && !i_txd_tready;
      stall_data = o_txd_tdata;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (acc && dec_q.size() != 0) begin
         void'(dec_q.pop_front());
         pending--;
      end
      if (push_pend) pending++;
      if (err_pend) err_exp = 1'b1;
      push_pend    = 0;
      err_pend     = 0;
      i_frame_end  = 1'b0;
      i_frame_len  = '0;
      tog          = !tog;
      i_txd_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? tog : 1'($urandom_range(0, 1));
      refresh();
      cyc++;
   endtask

   task automatic run_idle(int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || dec_q.size() != 0 || pending != 0) && n < limit) begin
         tick();
         n++;
      end
      check("drain_timeout", n < limit, 1);
      tick();
      tick();
      check("idle_ready", o_acl_ready, 0);
      check("idle_tvalid", o_txd_tvalid, 0);
      check("drop_words", dpop_cnt, drop_words_exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #12;
      check("rst_fifo_invalid", o_fifo_invalid, 1);
      check("rst_rd_valid", o_rd_valid, 0);
      check("rst_tvalid", o_txd_tvalid, 0);
      check("rst_tlast", o_txd_tlast, 0);
      check("rst_acl_ready", o_acl_ready, 0);
      check("rst_drop_cnt", o_drop_cnt, 0);
      check("rst_err", o_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      i_txd_tready = 1'b1;
      refresh();
      #1;
      check("post_rst_fifo_invalid", o_fifo_invalid, 0);

      // 16-word forwarded frame with tready held high
      hs_cnt = 0;
      push_frame(16, 1);
      tick();
      run_idle(200);
      check("t16_beats", hs_cnt, 16);
      check("t16_consecutive", last_hs - first_hs, 15);

      // 8-word dropped frame
      tvalid_seen = 0;
      push_frame(8, 0);
      tick();
      run_idle(200);
      check("t8_no_tvalid", tvalid_seen, 0);
      check("t8_drop_cnt", o_drop_cnt, exp_drop());

      // 4-word frame under alternating tready
      rdy_mode = 1;
      hs_cnt = 0;
      push_frame(4, 1);
      tick();
      run_idle(200);
      check("t4_beats", hs_cnt, 4);
      rdy_mode = 0;

      // zero-length pulse leaves queue occupancy alone
      hold_dec = 1;
      push_frame(2, 1);
      tick();
      push_frame(3, 0);
      tick();
      push_frame(0, 1);
      tick();
      check("len0_err", o_err, 1);
      check("len0_count_kept", o_fifo_invalid, 0);
      push_frame(1, 1);
      tick();
      check("len0_third_invalid", o_fifo_invalid, 1);
      hold_dec = 0;
      refresh();
      run_idle(300);

      // reset while the third word of a 10-word frame is presented
      hs_cnt = 0;
      push_frame(10, 1);
      tick();
      n = 0;
      while (hs_cnt < 2 && n < 50) begin
         tick();
         n++;
      end
      check("t10_reached_word3", n < 50, 1);
      check("t10_word3_valid", o_txd_tvalid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_tvalid", o_txd_tvalid, 0);
      check("async_rd_valid", o_rd_valid, 0);
      check("async_tlast", o_txd_tlast, 0);
      check("async_acl_ready", o_acl_ready, 0);
      check("async_fifo_invalid", o_fifo_invalid, 1);
      check("async_err", o_err, 0);
      check("async_drop_cnt", o_drop_cnt, 0);
      fifo_q.delete();
      exp_q.delete();
      dec_q.delete();
      pending = 0;
      err_exp = 1'b0;
      drop_exp = 0;
      drop_words_exp = 0;
      dpop_cnt = 0;
      stall_prev = 0;
      refresh();
      @(posedge clk);
      #2;
      rst = 1'b0;
      tick();
      check("after_rst_ready", o_acl_ready, 0);
      check("after_rst_tvalid", o_txd_tvalid, 0);

      // fill the length queue with no decisions, then overflow it
      hold_dec = 1;
      refresh();
      for (int k = 1; k <= 5; k++) begin
         push_frame(3, k[0]);
         tick();
         if (k == 2) check("fill2_invalid", o_fifo_invalid, 0);
         if (k == 3) check("fill3_invalid", o_fifo_invalid, 1);
         if (k == 4) check("fill4_err", o_err, 0);
         if (k == 5) check("fill5_err", o_err, 1);
      end
      hold_dec = 0;
      refresh();
      run_idle(300);

      // randomized traffic
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 3)) tick();
         n = 0;
         while (pending >= 3 && n < 100) begin
            tick();
            n++;
         end
         push_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)));
         tick();
      end
      run_idle(3000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
